// File: rtl/br_dump.sv
// Debug reader that walks the rv32i register bank through a borrowed read port
// and streams {address, data} beats out. Define BR_DUMP_CSUM_EN to append an XOR checksum beat.
module br_dump #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          req,
  input  logic          gnt,
  output logic [AW-1:0] ra,
  input  logic [DW-1:0] rd,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_data,
  output logic          m_last
);

`ifdef BR_DUMP_CSUM_EN
  typedef enum logic [2:0] {IDLE, REQ, SEND, CSUM, DONE} state_t;
  logic [DW-1:0] csum;
`else
  typedef enum logic [2:0] {IDLE, REQ, SEND, DONE} state_t;
`endif

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  state_t        state;
  logic [AW-1:0] idx;

  // The read port is only held for the REQ cycles; backpressure is absorbed in SEND.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      req     <= 1'b0;
      ra      <= '0;
      idx     <= '0;
      m_valid <= 1'b0;
      m_addr  <= '0;
      m_data  <= '0;
      m_last  <= 1'b0;
`ifdef BR_DUMP_CSUM_EN
      csum    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= REQ;
            busy  <= 1'b1;
            req   <= 1'b1;
            ra    <= '0;
            idx   <= '0;
`ifdef BR_DUMP_CSUM_EN
            csum  <= '0;
`endif
          end
        end
        REQ: begin
          if (gnt) begin
            state   <= SEND;
            req     <= 1'b0;
            m_valid <= 1'b1;
            m_addr  <= idx;
            m_data  <= rd;
`ifdef BR_DUMP_CSUM_EN
            m_last  <= 1'b0;
            csum    <= csum ^ rd;
`else
            m_last  <= (idx == LAST);
`endif
          end
        end
        SEND: begin
          if (m_ready) begin
            if (idx != LAST) begin
              state   <= REQ;
              m_valid <= 1'b0;
              idx     <= idx + ONE;
              ra      <= idx + ONE;
              req     <= 1'b1;
            end else begin
`ifdef BR_DUMP_CSUM_EN
              // Checksum already includes the final word sampled in REQ.
              state   <= CSUM;
              m_valid <= 1'b1;
              m_addr  <= '0;
              m_data  <= csum;
              m_last  <= 1'b1;
`else
              state   <= DONE;
              m_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
`endif
            end
          end
        end
`ifdef BR_DUMP_CSUM_EN
        CSUM: begin
          if (m_ready) begin
            state   <= DONE;
            m_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
`endif
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_br_dump.sv
// Self-checking bench for br_dump: a register-bank model drives rd and a
// scoreboard queue of expected beats is compared against every handshake.
module tb_br_dump;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;
`ifdef BR_DUMP_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int NBEATS = NREG + CS;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          req;
  logic          gnt;
  logic [AW-1:0] ra;
  logic [DW-1:0] rd;
  logic          m_valid;
  logic          m_ready;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_last;

  logic [DW-1:0] regs [NREG];
  beat_t         q [$];
  int            vectors;
  int            miscompares;
  int            beats;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;

  br_dump #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .req     (req),
    .gnt     (gnt),
    .ra      (ra),
    .rd      (rd),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_addr  (m_addr),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  assign rd = regs[ra];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beats are sampled mid-cycle; inputs only move just after the rising edge.
  always @(negedge clk) begin
    if (rst && m_valid && m_ready) begin
      beat_t e;
      beats++;
      last_addr = m_addr;
      last_data = m_data;
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL beat_extra: got addr=%0d data=%h last=%b, expected no beat", m_addr, m_data, m_last);
      end else begin
        e = q.pop_front();
        if (m_addr !== e.addr || m_data !== e.data || m_last !== e.last) begin
          miscompares++;
          $display("[TB] FAIL beat: got addr=%0d data=%h last=%b, expected addr=%0d data=%h last=%b",
                   m_addr, m_data, m_last, e.addr, e.data, e.last);
        end
      end
    end
  end

  task automatic push_dump();
    logic [DW-1:0] x;
    beat_t b;
    x = '0;
    for (int i = 0; i < NREG; i++) begin
      b.addr = AW'(i);
      b.data = regs[i];
      b.last = (CS == 0) && (i == NREG - 1);
      q.push_back(b);
      x = x ^ regs[i];
    end
    if (CS == 1) begin
      b.addr = '0;
      b.data = x;
      b.last = 1'b1;
      q.push_back(b);
    end
  endtask

  task automatic start_dump();
    push_dump();
    beats = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit found;
    found = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done) begin
        found = 1;
        break;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("[TB] FAIL %s_done_timeout: got no done, expected done within 400 cycles", tag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    gnt = 1'b1;
    m_ready = 1'b1;
    #3;
    vectors++;
    if ({busy, done, req, m_valid, m_last} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got busy/done/req/valid/last=%b, expected 00000", {busy, done, req, m_valid, m_last});
    end
    vectors++;
    if (ra !== '0 || m_addr !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_addr: got ra=%0d m_addr=%0d, expected 0 0", ra, m_addr);
    end
    vectors++;
    if (m_data !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got %h, expected 0", m_data);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_wait();
    int last_e;
    last_e = 2 * NREG + CS;
    for (int i = 0; i < NREG; i++) regs[i] = $urandom;
    regs[0] = '0;
    regs[1] = 32'h0000_0001;
    regs[2] = 32'hDEAD_BEEF;
    start_dump();
    for (int e = 0; e <= last_e + 1; e++) begin
      @(negedge clk);
      if (e == 0) begin
        vectors++;
        if ({busy, req, m_valid} !== 3'b110) begin
          miscompares++;
          $display("[TB] FAIL zw_edge0: got busy/req/valid=%b, expected 110", {busy, req, m_valid});
        end
      end
      if (e == 1) begin
        vectors++;
        if ({m_valid, req} !== 2'b10 || m_addr !== '0) begin
          miscompares++;
          $display("[TB] FAIL zw_edge1: got valid/req=%b addr=%0d, expected 10 addr 0", {m_valid, req}, m_addr);
        end
      end
      if (e == last_e - 1) begin
        vectors++;
        if (done !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL zw_done_early: got %b, expected 0", done);
        end
      end
      if (e == last_e) begin
        vectors++;
        if ({done, busy} !== 2'b10) begin
          miscompares++;
          $display("[TB] FAIL zw_done: got done/busy=%b, expected 10", {done, busy});
        end
      end
      if (e == last_e + 1) begin
        vectors++;
        if (done !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL zw_done_pulse: got %b, expected 0", done);
        end
      end
      @(posedge clk);
      #1;
    end
    vectors++;
    if (beats !== NBEATS) begin
      miscompares++;
      $display("[TB] FAIL zw_beats: got %0d, expected %0d", beats, NBEATS);
    end
  endtask

  task automatic test_gnt_stall();
    bit found;
    for (int i = 0; i < NREG; i++) regs[i] = 32'h1111_0000 + 32'(i);
    start_dump();
    found = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (m_valid && m_addr == AW'(2)) begin
        found = 1;
        break;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("[TB] FAIL stall_find: got no beat 2, expected one");
    end
    @(posedge clk);
    #1 gnt = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if ({req, m_valid} !== 2'b10 || ra !== AW'(3)) begin
        miscompares++;
        $display("[TB] FAIL stall_hold%0d: got req/valid=%b ra=%0d, expected 10 ra 3", k, {req, m_valid}, ra);
      end
      @(posedge clk);
      #1;
    end
    gnt = 1'b1;
    @(negedge clk);
    vectors++;
    if (m_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_early: got valid=%b, expected 0", m_valid);
    end
    @(negedge clk);
    vectors++;
    if (m_valid !== 1'b1 || m_addr !== AW'(3)) begin
      miscompares++;
      $display("[TB] FAIL stall_release: got valid=%b addr=%0d, expected 1 addr 3", m_valid, m_addr);
    end
    wait_done("stall");
    @(posedge clk);
    #1;
    vectors++;
    if (beats !== NBEATS) begin
      miscompares++;
      $display("[TB] FAIL stall_beats: got %0d, expected %0d", beats, NBEATS);
    end
  endtask

  task automatic test_backpressure();
    bit found;
    for (int i = 0; i < NREG; i++) regs[i] = $urandom;
    regs[0] = '0;
    start_dump();
    found = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (req && ra == AW'(7)) begin
        found = 1;
        break;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("[TB] FAIL bp_find: got no request for 7, expected one");
    end
    @(posedge clk);
    #1 m_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if ({m_valid, req} !== 2'b10 || m_addr !== AW'(7) || m_data !== regs[7]) begin
        miscompares++;
        $display("[TB] FAIL bp_hold%0d: got valid/req=%b addr=%0d data=%h, expected 10 addr 7 data %h",
                 k, {m_valid, req}, m_addr, m_data, regs[7]);
      end
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    wait_done("bp");
    @(posedge clk);
    #1;
    vectors++;
    if (beats !== NBEATS) begin
      miscompares++;
      $display("[TB] FAIL bp_beats: got %0d, expected %0d", beats, NBEATS);
    end
  endtask

  task automatic test_start_drop();
    for (int i = 0; i < NREG; i++) regs[i] = $urandom;
    regs[0] = '0;
    start_dump();
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("drop");
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, m_valid, req} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL drop_idle: got busy/valid/req=%b, expected 000", {busy, m_valid, req});
    end
    vectors++;
    if (beats !== NBEATS || q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drop_beats: got %0d beats, %0d pending, expected %0d beats, 0 pending", beats, q.size(), NBEATS);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bit found;
    for (int i = 0; i < NREG; i++) regs[i] = $urandom;
    regs[0] = '0;
    start_dump();
    found = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (m_valid && m_addr == AW'(10)) begin
        found = 1;
        break;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("[TB] FAIL rstmid_find: got no beat 10, expected one");
    end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    vectors++;
    if ({m_valid, req, busy, done} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL rstmid_async: got valid/req/busy/done=%b, expected 0000", {m_valid, req, busy, done});
    end
    q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rstmid_done%0d: got %b, expected 0", k, done);
      end
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    start_dump();
    wait_done("rstmid");
    @(posedge clk);
    #1;
    vectors++;
    if (beats !== NBEATS) begin
      miscompares++;
      $display("[TB] FAIL rstmid_beats: got %0d, expected %0d", beats, NBEATS);
    end
  endtask

`ifdef BR_DUMP_CSUM_EN
  task automatic test_csum();
    for (int i = 0; i < NREG; i++) regs[i] = '0;
    regs[2] = 32'hDEAD_BEEF;
    regs[5] = 32'h0000_FFFF;
    start_dump();
    wait_done("csum");
    @(posedge clk);
    #1;
    vectors++;
    if (last_addr !== '0 || last_data !== 32'hDEAD_4110) begin
      miscompares++;
      $display("[TB] FAIL csum_beat: got addr=%0d data=%h, expected addr 0 data DEAD4110", last_addr, last_data);
    end
    vectors++;
    if (beats !== NBEATS) begin
      miscompares++;
      $display("[TB] FAIL csum_beats: got %0d, expected %0d", beats, NBEATS);
    end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    beats = 0;
    for (int i = 0; i < NREG; i++) regs[i] = '0;
    test_reset();
    test_zero_wait();
    test_gnt_stall();
    test_backpressure();
    test_start_drop();
    test_reset_mid();
`ifdef BR_DUMP_CSUM_EN
    test_csum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/br_dump.md
# br_dump

Debug reader for the rv32i register bank (BR). On a start pulse it borrows one BR read port through a req/gnt handshake, walks every architectural register in ascending order, and streams each {address, data} pair out on a valid/ready interface toward the debug/trace path. The datapath muxes `ra` onto its BR read-address input while `gnt` is high. The core stalls only for the single cycle in which a register is sampled.

## Interface
- `NREG`, 32, number of registers walked, from index 0 to NREG-1.
- `AW`, 5, register address width.
- `DW`, 32, register data width.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a dump; sampled only in IDLE, ignored otherwise.
- `busy`  out  1  high while in REQ, SEND or CSUM.
- `done`  out  1  one-cycle pulse after the final beat's handshake.
- `req`  out  1  request for the BR read port.
- `gnt`  in  1  datapath grants the read port; `ra` is applied to BR this cycle.
- `ra`  out  AW  BR read address.
- `rd`  in  DW  BR read data (combinational from `ra`).
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  sink accepts the beat.
- `m_addr`  out  AW  register index of the beat.
- `m_data`  out  DW  register contents, or the checksum beat.
- `m_last`  out  1  marks the final beat of a dump.

## Operation
- Reset values: state IDLE, `busy` 0, `done` 0, `req` 0, `ra` 0, `m_valid` 0, `m_addr` 0, `m_data` 0, `m_last` 0, index 0, checksum 0.
- IDLE: on `start`=1, go to REQ. Clear the index and checksum.
- REQ: `req`=1, `ra`=index.
  - If `gnt`=1 at the edge: register `m_addr`=index, `m_data`=`rd`, `m_last`=(index==NREG-1 and no checksum), and checksum ^= `rd`. Go to SEND.
  - If `gnt`=0, stay in REQ and keep `ra` stable.
- SEND: `req`=0, `m_valid`=1, and all m_* fields hold stable until `m_ready`=1. On handshake:
  - index < NREG-1: increment index, go to REQ.
  - index == NREG-1: go to CSUM if enabled, else DONE.
- CSUM (only with the macro): `m_valid`=1, `m_addr`=0, `m_data`=checksum, `m_last`=1. On handshake go to DONE.
- DONE: `done`=1 for one cycle, then IDLE. `busy`=0.
- `gnt` while `req`=0 is ignored. `start` while busy or in DONE is dropped, not queued.
- x0 is dumped like any other register; its value is whatever BR returns (0).
- Index is AW bits wide. The terminal compare is against NREG-1, so there is no wrap. NREG must be ≤ 2^AW.

## Timing
- BR read is combinational: `rd` is sampled on the same edge at which `gnt` and `req` are both high.
- `req` is never high during SEND, so sink backpressure never stalls the core.
- Zero-wait case (`gnt`=1 and `m_ready`=1 always): 2 cycles per register. `start` sampled at edge 0, first `m_valid` after edge 1, last handshake at edge 2·NREG (64), `done` high in the cycle after edge 64. With the checksum: one extra cycle.
- `m_valid` never drops without a handshake, except on reset.
- Reset mid-dump, asynchronously: all outputs return to their reset values immediately and no `done` is produced. The next dump restarts at index 0.

## Configuration
- `BR_DUMP_CSUM_EN` defined: one extra CSUM beat carrying the XOR of all NREG data words, and only that beat has `m_last`=1. A dump is NREG+1 beats.
- Not defined: no CSUM state and no checksum register. `m_last`=1 on the index NREG-1 beat. A dump is NREG beats.

## Test plan
- Preload x2=DEADBEEF and x1=00000001, with `gnt`=`m_ready`=1 and `start` pulsed. Required: 32 beats with addr 0..31 in order, beat 0 data 0, beat 1 data 00000001, beat 2 data DEADBEEF. `done` is high the cycle after edge 64.
- `gnt` held 0 for 5 cycles in REQ at index 3. Required: `req`=1 and `ra`=3 stable throughout, no beat emitted. The beat is emitted one cycle after `gnt` rises.
- `m_ready` held 0 for 4 cycles on beat 7. Required: `m_valid`, `m_addr`=7 and `m_data` stable, with `req`=0 the whole time.
- `start` pulsed while busy, and again in the DONE cycle. Required: exactly one dump, no extra beats.
- `rst` asserted after beat 10. Required: `m_valid`, `req` and `busy` are 0 immediately and no `done`. The next `start` yields beat 0 first.
- With `BR_DUMP_CSUM_EN`, all registers 0 except x2=DEADBEEF and x5=0000FFFF. Required: 33rd beat with addr 0, data DEAD4110, `m_last`=1. Beat 31 has `m_last`=0.
